apx_mult_sweep_ctrl: RTL and testbench
======================================

// Module: apx_mult_sweep_ctrl
// PURPOSE
//  Hardware error-characterisation engine for the approximate multiplier.
//  On start, sweeps every operand pair (A,B) through an external combinational approximate
//  multiplier and compares each product with the exact A*B. Accumulates sum, max and count
//  of absolute error. Sits beside approximate_multiplier_4x4 on-chip, replacing offline
//  exhaustive simulation.
// PARAMETERS
//  W      4   operand width; sweep length N = 2**(2W) pairs
//  ACC_W  16  err_sum / err_bias width (saturating)
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       reset, asynchronous, active-high
//  start     in   1       begin a sweep; sampled only in IDLE
//  abort     in   1       cancel a sweep in RUN/DRAIN
//  busy      out  1       high in RUN and DRAIN
//  done      out  1       one-cycle pulse; results final
//  mult_a    out  W       operand A to multiplier (sweep index high half)
//  mult_b    out  W       operand B to multiplier (sweep index low half)
//  mult_p    in   2W      approximate product returned combinationally
//  err_sum   out  ACC_W   sum |p - A*B|, saturates at all-ones
//  err_max   out  2W      max |p - A*B|
//  err_cnt   out  2W+1    number of pairs with p != A*B
//  err_bias  out  ACC_W+1 signed sum (p - A*B); present only with macro
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, pipeline valids=0; all outputs 0.
//  FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE:  start=1 clears err_*, sets idx=0, moves to RUN.
//  RUN:   {mult_a,mult_b}=idx; idx increments by 1 each cycle.
//         idx==N-1 moves to DRAIN; idx wraps to 0.
//  Pipe stage 1: registers A, B, mult_p and valid at the end of each RUN cycle.
//  Pipe stage 2: computes exact=A*B (2W bits) and err=|p-exact|;
//         updates sum (sat), max and cnt when stage-1 valid is set.
//  DRAIN: exactly 2 cycles, until stage-2 update of the last pair. Then DONE.
//  DONE:  done=1 for one cycle, then IDLE. err_* hold until the next accepted start.
//  Latency: done rises N+2 edges after the edge that samples start (258 for W=4).
//  start while busy: ignored. start and abort together in IDLE: start wins.
//  abort in RUN/DRAIN: next state IDLE, valids cleared, no done pulse,
//         err_* hold partial values. abort in IDLE/DONE: no effect.
//  rst mid-sweep: immediate return to reset values.
//  mult_a/mult_b hold the last driven value outside RUN.
//  Error arithmetic is unsigned 2W-bit. Saturation applies to err_sum only.
// CONFIGURATION
//  APX_SWEEP_BIAS_EN defined: err_bias accumulates signed (p - A*B),
//         saturating at the signed limits; cleared on start like err_*.
//  Not defined: err_bias port tied to 0, no accumulator logic.
// STRUCTURE
//  Package apx_sweep_pkg: FSM state enum (IDLE/RUN/DRAIN/DONE), DRAIN_CYC=2,
//         abs_diff and sat_add functions.
//  Sub-module apx_err_acc: stage-2 accumulator (sum/max/cnt/bias). FSM and idx stay in top.
//  Multiplier under test is instantiated outside and wired via mult_a/mult_b/mult_p.
// TESTING
//  1 Stub p=A*B, pulse start -> err_sum=0, err_max=0, err_cnt=0; done at edge 258; busy for 258 cycles.
//  2 Stub p=(A*B)|1 -> err_sum=192, err_max=1, err_cnt=192.
//  3 Stub p=0 -> err_sum=14400, err_max=225, err_cnt=225; with macro err_bias=-14400.
//  4 ACC_W=8, stub p=0 -> err_sum=255 (saturated), err_max=225.
//  5 abort at RUN idx=100 -> busy low next cycle, no done; start pulsed mid-RUN in a fresh sweep is ignored, done still at edge 258.
//  6 rst asserted at idx=50 -> all outputs 0 asynchronously; new start gives the results of scenario 1 unchanged.

Source files
------------

// File: rtl/apx_sweep_pkg.sv
// Shared types and helpers for the approximate-multiplier error sweep engine.
// Build option APX_SWEEP_BIAS_EN (see apx_err_acc) adds the signed bias accumulator.
package apx_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sweep_state_e;

  // Cycles spent in DRAIN so the last pair clears both pipeline stages.
  localparam int unsigned DRAIN_CYC = 2;

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Unsigned add clamped to the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/apx_err_acc.sv
// Stage-2 error accumulator: exact product, |p - A*B|, saturating sum, max and count.
// With APX_SWEEP_BIAS_EN defined, also accumulates the signed error (p - A*B), saturating.
module apx_err_acc
  import apx_sweep_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   p,
  output logic [ACC_W-1:0] err_sum,
  output logic [2*W-1:0]   err_max,
  output logic [2*W:0]     err_cnt,
  output logic [ACC_W:0]   err_bias
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0]    exact;
  logic [PW-1:0]    err;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [PW-1:0]    max_q, max_d;
  logic [PW:0]      cnt_q, cnt_d;

  always_comb begin
    exact = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    err   = PW'(abs_diff(32'(p), 32'(exact)));
    sum_d = sum_q;
    max_d = max_q;
    cnt_d = cnt_q;
    if (clr) begin
      sum_d = '0;
      max_d = '0;
      cnt_d = '0;
    end else if (en) begin
      sum_d = ACC_W'(sat_add(32'(sum_q), 32'(err), ACC_W));
      if (err > max_q) max_d = err;
      if (err != '0) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_sum = sum_q;
  assign err_max = max_q;
  assign err_cnt = cnt_q;

`ifdef APX_SWEEP_BIAS_EN
  localparam int unsigned BiasW = ACC_W + 1;
  localparam int unsigned ExtW  = ACC_W + 2;
  localparam logic signed [ExtW-1:0] BiasMax = $signed({2'b00, {ACC_W{1'b1}}});
  localparam logic signed [ExtW-1:0] BiasMin = $signed({2'b11, {ACC_W{1'b0}}});

  logic signed [BiasW-1:0] bias_q, bias_d;
  logic signed [PW:0]      diff;
  logic signed [ExtW-1:0]  bias_ext;

  always_comb begin
    diff     = $signed({1'b0, p}) - $signed({1'b0, exact});
    bias_ext = ExtW'(bias_q) + ExtW'(diff);
    bias_d   = bias_q;
    if (clr) begin
      bias_d = '0;
    end else if (en) begin
      if (bias_ext > BiasMax)      bias_d = BiasMax[BiasW-1:0];
      else if (bias_ext < BiasMin) bias_d = BiasMin[BiasW-1:0];
      else                         bias_d = bias_ext[BiasW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bias_q <= '0;
    else     bias_q <= bias_d;
  end

  assign err_bias = bias_q;
`else
  assign err_bias = '0;
`endif

endmodule

// File: rtl/apx_mult_sweep_ctrl.sv
// Error-characterisation sweep controller: drives every (A,B) pair to an external multiplier
// and accumulates error statistics. Optional signed bias output via APX_SWEEP_BIAS_EN.
module apx_mult_sweep_ctrl
  import apx_sweep_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     mult_a,
  output logic [W-1:0]     mult_b,
  input  logic [2*W-1:0]   mult_p,
  output logic [ACC_W-1:0] err_sum,
  output logic [2*W-1:0]   err_max,
  output logic [2*W:0]     err_cnt,
  output logic [ACC_W:0]   err_bias
);

  localparam int unsigned IdxW = 2 * W;
  localparam logic [IdxW-1:0] IdxLast = '1;
  localparam logic [1:0] DrainLast = 2'(DRAIN_CYC - 1);

  sweep_state_e    state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] op_q, op_d;
  logic [1:0]      drain_q, drain_d;
  logic            acc_clr;
  logic            run;

  logic            s1_valid_q, s1_valid_d;
  logic [W-1:0]    s1_a_q, s1_a_d;
  logic [W-1:0]    s1_b_q, s1_b_d;
  logic [IdxW-1:0] s1_p_q, s1_p_d;
  logic            acc_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    drain_d = drain_q;
    acc_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
          acc_clr = 1'b1;
        end
      end
      StRun: begin
        op_d  = idx_q;
        idx_d = idx_q + 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (idx_q == IdxLast) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign run  = (state_q == StRun);
  assign busy = run || (state_q == StDrain);
  assign done = (state_q == StDone);

  // Outside RUN the operands hold whatever pair was last presented.
  assign {mult_a, mult_b} = run ? idx_q : op_q;

  always_comb begin
    s1_valid_d = run && !abort;
    s1_a_d     = run ? mult_a : s1_a_q;
    s1_b_d     = run ? mult_b : s1_b_q;
    s1_p_d     = run ? mult_p : s1_p_q;
  end

  // An abort also cancels the pair already in flight in stage 1.
  assign acc_en = s1_valid_q && !(abort && busy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      op_q       <= '0;
      drain_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_p_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      drain_q    <= drain_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_p_q     <= s1_p_d;
    end
  end

  apx_err_acc #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_err_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .en       (acc_en),
    .a        (s1_a_q),
    .b        (s1_b_q),
    .p        (s1_p_q),
    .err_sum  (err_sum),
    .err_max  (err_max),
    .err_cnt  (err_cnt),
    .err_bias (err_bias)
  );

endmodule

// File: tb/tb_apx_mult_sweep_ctrl.sv
// Scoreboard bench for apx_mult_sweep_ctrl: ACC_W=16 and ACC_W=8 instances share stimulus.
// Bias expectations follow APX_SWEEP_BIAS_EN.
module tb_apx_mult_sweep_ctrl;

  typedef struct {
    int sum;
    int max;
    int cnt;
    int bias;
    int sum8;
    int bias8;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  int          stub_mode = 0;

  logic        busy, done;
  logic [3:0]  mult_a, mult_b;
  logic [7:0]  mult_p;
  logic [15:0] err_sum;
  logic [7:0]  err_max;
  logic [8:0]  err_cnt;
  logic [16:0] err_bias;

  logic        busy8, done8;
  logic [3:0]  mult_a8, mult_b8;
  logic [7:0]  mult_p8;
  logic [7:0]  err_sum8;
  logic [7:0]  err_max8;
  logic [8:0]  err_cnt8;
  logic [8:0]  err_bias8;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  function automatic int stub_val(input int a, input int b, input int mode);
    case (mode)
      0:       return a * b;
      1:       return (a * b) | 1;
      default: return 0;
    endcase
  endfunction

  always_comb begin
    mult_p  = 8'(stub_val(int'(mult_a), int'(mult_b), stub_mode));
    mult_p8 = 8'(stub_val(int'(mult_a8), int'(mult_b8), stub_mode));
  end

  apx_mult_sweep_ctrl #(.W(4), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p), .err_sum(err_sum),
    .err_max(err_max), .err_cnt(err_cnt), .err_bias(err_bias)
  );

  apx_mult_sweep_ctrl #(.W(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy8), .done(done8),
    .mult_a(mult_a8), .mult_b(mult_b8), .mult_p(mult_p8), .err_sum(err_sum8),
    .err_max(err_max8), .err_cnt(err_cnt8), .err_bias(err_bias8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got,
                  $signed(exp), exp);
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic exp_t model(input int mode);
    exp_t e;
    int   d, ad, raw_sum, raw_bias;
    e = '{default: 0};
    raw_sum = 0;
    raw_bias = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        d  = stub_val(a, b, mode) - a * b;
        ad = (d < 0) ? -d : d;
        raw_sum += ad;
        raw_bias += d;
        if (ad > e.max) e.max = ad;
        if (ad != 0) e.cnt++;
      end
    end
    e.sum  = clamp(raw_sum, 0, 65535);
    e.sum8 = clamp(raw_sum, 0, 255);
`ifdef APX_SWEEP_BIAS_EN
    e.bias  = clamp(raw_bias, -65536, 65535);
    e.bias8 = clamp(raw_bias, -256, 255);
`else
    e.bias  = 0;
    e.bias8 = 0;
`endif
    return e;
  endfunction

  // Full sweep; inject>0 pulses start again that many edges into the run.
  task automatic run_sweep(input int mode, input int inject);
    int   cnt, busy_cnt;
    bit   got;
    exp_t e;
    stub_mode = mode;
    sb_q.push_back(model(mode));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    cnt = 0;
    got = 1'b0;
    while (cnt < 1000 && !got) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      start = (cnt == inject);
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    if (!got) begin
      check_eq("done_timeout", 32'(cnt), 32'd258);
      return;
    end
    check_eq("latency", 32'(cnt), 32'd258);
    check_eq("busy_cycles", 32'(busy_cnt), 32'd258);
    check_eq("err_sum", 32'(err_sum), 32'(e.sum));
    check_eq("err_max", 32'(err_max), 32'(e.max));
    check_eq("err_cnt", 32'(err_cnt), 32'(e.cnt));
    check_eq("err_bias", 32'($signed(err_bias)), 32'(e.bias));
    check_eq("err_sum8", 32'(err_sum8), 32'(e.sum8));
    check_eq("err_max8", 32'(err_max8), 32'(e.max));
    check_eq("err_cnt8", 32'(err_cnt8), 32'(e.cnt));
    check_eq("err_bias8", 32'($signed(err_bias8)), 32'(e.bias8));
    check_eq("done8_aligned", 32'(done8), 32'd1);
    check_eq("hold_ab", 32'({mult_a, mult_b}), 32'hff);
    @(negedge clk);
    check_eq("done_one_cycle", 32'({done, busy}), 32'd0);
    check_eq("err_sum_holds", 32'(err_sum), 32'(e.sum));
  endtask

  task automatic wait_idx(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (busy && {mult_a, mult_b} == 8'(target)) ok = 1'b1;
    end
    if (!ok) check_eq("wait_idx_timeout", 32'(target), 32'hffff_ffff);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok;
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy_done", 32'({busy, done}), 32'd0);
    check_eq("rst_ab", 32'({mult_a, mult_b}), 32'd0);
    check_eq("rst_sum", 32'(err_sum), 32'd0);
    check_eq("rst_max_cnt", 32'({err_max, err_cnt}), 32'd0);
    check_eq("rst_bias", 32'(err_bias), 32'd0);

    run_sweep(0, 0);
    run_sweep(1, 77);
    run_sweep(2, 0);

    // Abort at idx 100.
    stub_mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idx(100, ok);
    if (ok) begin
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_hold_ab", 32'({mult_a, mult_b}), 32'd100);
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (done || busy) seen = 1'b1;
      end
      check_eq("abort_no_done", 32'(seen), 32'd0);
    end

    // Asynchronous reset at idx 50.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idx(50, ok);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'({busy, done}), 32'd0);
    check_eq("arst_ab", 32'({mult_a, mult_b}), 32'd0);
    check_eq("arst_err", 32'({err_sum, err_max, err_cnt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
